// File: rtl/macro_fifo8_pkg.sv
// -----------------------------------------------------------------------------
// macro_fifo8_pkg
// Shared constants and types for the 8-entry pointer-controlled FIFO.
//   DEPTH  : number of storage entries
//   PTR_W  : pointer index width (log2 DEPTH)
//   CNT_W  : occupancy width, wide enough for 0..DEPTH
//   ptr_t  : pointer index plus the phase bit that flips on every wrap
// -----------------------------------------------------------------------------
package macro_fifo8_pkg;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;
  localparam int CNT_W = 4;

  // The phase bit tells "same lap" from "one lap ahead" when indices match.
  typedef struct packed {
    logic             ph;
    logic [PTR_W-1:0] idx;
  } ptr_t;

  function automatic logic ptr_empty(input ptr_t wr, input ptr_t rd);
    return (wr.idx == rd.idx) && (wr.ph == rd.ph);
  endfunction

  function automatic logic ptr_full(input ptr_t wr, input ptr_t rd);
    return (wr.idx == rd.idx) && (wr.ph != rd.ph);
  endfunction

endpackage

// File: rtl/macro_rom_incr3.sv
// -----------------------------------------------------------------------------
// macro_rom_incr3
// Combinational 3-bit unsigned increment table.
//   d : input value 0..7
//   q : (d + 1) mod 8
//   c : carry, high only when d = 7 (wrap to 0)
// -----------------------------------------------------------------------------
module macro_rom_incr3 (
  input  logic [2:0] d,
  output logic [2:0] q,
  output logic       c
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can leave
    // a value unassigned, which would otherwise infer a latch.
    q = 3'd0;
    c = 1'b0;
    case (d)
      3'd0: q = 3'd1;
      3'd1: q = 3'd2;
      3'd2: q = 3'd3;
      3'd3: q = 3'd4;
      3'd4: q = 3'd5;
      3'd5: q = 3'd6;
      3'd6: q = 3'd7;
      3'd7: begin
        q = 3'd0;
        c = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/macro_fifo8_ptrctl.sv
// -----------------------------------------------------------------------------
// macro_fifo8_ptrctl
// 8-entry first-word-fall-through FIFO with phase-bit pointer control.
// Full/empty come from comparing read and write pointers including the phase
// bit, so no separate occupancy register is needed for flow control.
//
// Build option:
//   MACRO_FIFO8_COUNT_EN  defined   -> count is a registered occupancy counter
//                         undefined -> count is tied to 0
//
// Ports:
//   clk      : clock, all state on rising edge
//   reset    : synchronous active-high reset (pointers only, not storage)
//   s_valid  : push request
//   s_ready  : not full
//   s_data   : push payload [DATA_W]
//   m_valid  : not empty
//   m_ready  : pop acceptance
//   m_data   : head-of-queue payload [DATA_W], valid only with m_valid
//   count    : occupancy 0..8 (see build option)
// -----------------------------------------------------------------------------
module macro_fifo8_ptrctl
  import macro_fifo8_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CNT_W-1:0]  count
);

  ptr_t             wr;
  ptr_t             rd;
  logic [PTR_W-1:0] wr_idx_nxt;
  logic [PTR_W-1:0] rd_idx_nxt;
  logic             wr_carry;
  logic             rd_carry;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  logic [DATA_W-1:0] mem [DEPTH];

  // Pointer successors come from the shared increment table.
  macro_rom_incr3 u_wr_incr (
    .d (wr.idx),
    .q (wr_idx_nxt),
    .c (wr_carry)
  );

  macro_rom_incr3 u_rd_incr (
    .d (rd.idx),
    .q (rd_idx_nxt),
    .c (rd_carry)
  );

  // Flow control depends on registered pointers only, never on the
  // requesting side's valid/ready, so there is no combinational loop.
  assign full    = ptr_full(wr, rd);
  assign empty   = ptr_empty(wr, rd);
  assign s_ready = !full;
  assign m_valid = !empty;

  assign push = s_valid && s_ready;
  assign pop  = m_valid && m_ready;

  // Fall-through read: the head entry is visible as soon as it is written.
  assign m_data = mem[rd.idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      wr <= '0;
      rd <= '0;
    end else begin
      if (push) begin
        wr.idx <= wr_idx_nxt;
        wr.ph  <= wr.ph ^ wr_carry;
      end
      if (pop) begin
        rd.idx <= rd_idx_nxt;
        rd.ph  <= rd.ph ^ rd_carry;
      end
    end
  end

  // NOTE: the storage array has no reset; contents behind the read pointer
  // are never observed, and leaving it unreset lets it map to plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr.idx] <= s_data;
    end
  end

`ifdef MACRO_FIFO8_COUNT_EN
  logic [CNT_W-1:0] occ;

  always_ff @(posedge clk) begin
    if (reset) begin
      occ <= '0;
    end else begin
      case ({push, pop})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign count = occ;
`else
  assign count = 4'd0;
`endif

endmodule

// File: tb/tb_macro_fifo8_ptrctl.sv
// -----------------------------------------------------------------------------
// tb_macro_fifo8_ptrctl
// Randomized scoreboard bench for macro_fifo8_ptrctl. A queue-based reference
// model tracks FIFO contents; a separate monitor pops expected data whenever
// the DUT completes a read handshake. Also checks macro_rom_incr3 standalone.
// Honors MACRO_FIFO8_COUNT_EN for the expected count value.
// -----------------------------------------------------------------------------
module tb_macro_fifo8_ptrctl;
  import macro_fifo8_pkg::*;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [CNT_W-1:0]  count;

  logic [2:0] rom_d;
  logic [2:0] rom_q;
  logic       rom_c;

  int vectors     = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] model_q [$];
  logic [DATA_W-1:0] sb_q    [$];

  always #5 clk = ~clk;

  macro_fifo8_ptrctl #(.DATA_W(DATA_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .count   (count)
  );

  macro_rom_incr3 u_rom (
    .d (rom_d),
    .q (rom_q),
    .c (rom_c)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CNT_W-1:0] exp_count();
`ifdef MACRO_FIFO8_COUNT_EN
    return CNT_W'(model_q.size());
`else
    return '0;
`endif
  endfunction

  // One clock of stimulus: drive just after a rising edge, check outputs at
  // the falling edge against the model, then advance the model to match what
  // the coming rising edge should do.
  task automatic cycle(input logic rst, input logic v, input logic [DATA_W-1:0] d,
                       input logic r);
    bit push_ok;
    bit pop_ok;
    reset   = rst;
    s_valid = v;
    s_data  = d;
    m_ready = r;
    @(negedge clk);
    check("s_ready", s_ready, model_q.size() < 8);
    check("m_valid", m_valid, model_q.size() > 0);
    check("count", count, exp_count());
    if (model_q.size() > 0) check("m_data", m_data, model_q[0]);
    if (rst) begin
      model_q.delete();
      sb_q.delete();
    end else begin
      push_ok = v && (model_q.size() < 8);
      pop_ok  = r && (model_q.size() > 0);
      if (pop_ok) void'(model_q.pop_front());
      if (push_ok) begin
        model_q.push_back(d);
        sb_q.push_back(d);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every completed read handshake must deliver the oldest pushed word.
  always @(negedge clk) begin
    logic [DATA_W-1:0] e;
    if (reset === 1'b0 && m_valid === 1'b1 && m_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL mon_underflow: got pop of 0x%0h expected no pop at %0t", m_data, $time);
      end else begin
        e = sb_q.pop_front();
        check("mon_data", m_data, e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    rom_d   = '0;

    // Reset state.
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);

    // Fill with 0x01..0x08, nothing popped; full afterwards.
    for (int i = 1; i <= 8; i++) cycle(1'b0, 1'b1, 8'(i), 1'b0);
    check("full_s_ready", s_ready, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);

    // From full: push and pop held for 8 cycles; first push blocked only.
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'($urandom), 1'b1);

    // Drain.
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Fall-through latency into an empty FIFO.
    cycle(1'b0, 1'b1, 8'hA5, 1'b0);
    check("fwft_valid", m_valid, 1'b1);
    check("fwft_data", m_data, 8'hA5);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Steady push+pop at occupancy 3, long enough to wrap the pointers.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 8'($urandom), 1'b1);

    // Reset at occupancy 5 alongside a push.
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 8'($urandom), 1'b0);
    cycle(1'b1, 1'b1, 8'($urandom), 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_count", count, 4'd0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);

    // Random traffic with occasional resets; bias alternates fill/drain.
    for (int i = 0; i < 400; i++) begin
      logic rst;
      logic v;
      logic r;
      rst = ($urandom_range(0, 59) == 0);
      if ((i / 50) % 2 == 0) begin
        v = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        v = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      cycle(rst, v, 8'($urandom), r);
    end

    // Increment table, exhaustively.
    for (int i = 0; i < 8; i++) begin
      rom_d = 3'(i);
      #1;
      check("rom_q", rom_q, (i + 1) % 8);
      check("rom_c", rom_c, i == 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/macro_fifo8_ptrctl.md
MACRO_FIFO8_PTRCTL -- requirements
Module: macro_fifo8_ptrctl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, the payload width in bits.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port s_valid  input  1  the upstream push request.
REQ-005 SHALL have port s_ready  output  1  asserted when the FIFO is not full.
REQ-006 SHALL have port s_data  input  DATA_W  the push payload.
REQ-007 SHALL have port m_valid  output  1  asserted when the FIFO is not empty.
REQ-008 SHALL have port m_ready  input  1  the downstream pop acceptance.
REQ-009 SHALL have port m_data  output  DATA_W  the head-of-queue payload.
REQ-010 SHALL have port count  output  4  the occupancy, 0..8.

Function
REQ-011 SHALL hold 8 entries of DATA_W, addressed by a 3-bit write pointer (wptr) and a 3-bit read pointer (rptr), each with a 1-bit phase (wph, rph).
REQ-012 SHALL accept a push when s_valid && s_ready, writing s_data at wptr.
REQ-013 SHALL accept a pop when m_valid && m_ready.
REQ-014 SHALL advance a pointer on acceptance as {carry, next} = ptr + 1 mod 8, toggling the matching phase bit when carry = 1 (7 -> 0).
REQ-015 SHALL flag empty when wptr == rptr && wph == rph, and full when wptr == rptr && wph != rph.
REQ-016 SHALL drive s_ready = !full and m_valid = !empty, both combinational from registered state, with no dependence on s_valid or m_ready.
REQ-017 SHALL drive m_data = mem[rptr] combinationally (first-word fall-through), so m_valid asserts 1 cycle after the first push into an empty FIFO.
REQ-018 SHALL, on a simultaneous push and pop while neither full nor empty, perform both, leaving count unchanged.
REQ-019 SHALL, when full, reject the push (s_ready = 0) and accept the pop, giving count 8 -> 7.
REQ-020 SHALL, when empty, accept the push and perform no pop (m_valid = 0), giving count 0 -> 1.
REQ-021 SHALL keep the handshake ports free of X-propagation: m_data is don't-care while m_valid = 0.

Reset
REQ-022 SHALL, while reset = 1 at a clock edge, load wptr = rptr = 0 and wph = rph = 0, which sets s_ready = 1, m_valid = 0 and count = 0 on the following cycle.
REQ-023 SHALL give reset priority over any push or pop in the same cycle, discarding all contents, including a mid-stream reset.
REQ-024 SHALL NOT reset the storage array.

Configuration
REQ-025 SHALL, when macro MACRO_FIFO8_COUNT_EN is defined, drive count from a registered 4-bit occupancy counter: +1 on push only, -1 on pop only, otherwise unchanged, reset to 0.
REQ-026 SHALL, when MACRO_FIFO8_COUNT_EN is undefined, omit that counter and tie count to 4'd0, with all other behaviour identical.

Structure
REQ-027 SHALL take DEPTH = 8 and PTR_W = 3 from the shared package macro_fifo8_pkg.
REQ-028 SHALL instantiate sub-module macro_rom_incr3 twice, once per pointer: a combinational 3-bit unsigned increment ROM with d[2:0] -> q[2:0] and carry c (c = 1 only for d = 7, q = 0).

Verification
REQ-029 SHALL cover: reset, then 8 pushes of 0x01..0x08 with m_ready = 0 -> s_ready = 0 after the 8th push; count = 8 if the macro is enabled.
REQ-030 SHALL cover: from full, hold s_valid = 1 and m_ready = 1 for 8 cycles -> pushes are blocked only in the first cycle; first popped data = 0x01.
REQ-031 SHALL cover: push 0xA5 into an empty FIFO -> m_valid = 1 and m_data = 0xA5 exactly one cycle later.
REQ-032 SHALL cover: 20 back-to-back push/pop cycles at occupancy 3 -> pointer wrap 7 -> 0 toggles the phase, count stays 3, and data order is preserved.
REQ-033 SHALL cover: assert reset at occupancy 5 alongside a push -> the next cycle shows m_valid = 0, s_ready = 1 and count = 0.
REQ-034 SHALL cover: exhaustive check of macro_rom_incr3 -> q = (d + 1) mod 8 and c = 1 only for d = 7.
